// File: rtl/strided_mover_pkg.sv
// Shared types and sizing helpers for the strided_mover block.
package strided_mover_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned CNT_W = $clog2(DEF_MAX_OUTSTANDING) + 1;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mover_fifo.sv
// Return-data FIFO: registered storage, combinational head, push and pop may coincide.
module mover_fifo
  import strided_mover_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DEF_MAX_OUTSTANDING
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   din_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   dout_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (pop_i)  rptr_d = rptr_q + PW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/strided_mover.sv
// Pipelined strided copy engine between two TwoPortBuffers, credit-limited read issue.
// Optional constant-fill mode is compiled in with STRIDED_MOVER_FILL_EN.
module strided_mover
  import strided_mover_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_base_addr,
  input  logic [ADDR_WIDTH-1:0] dst_base_addr,
  input  logic [ADDR_WIDTH-1:0] src_stride,
  input  logic [ADDR_WIDTH-1:0] dst_stride,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic                  fill_mode,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] src_rd_addr,
  output logic                  src_rd_csb,
  input  logic [DATA_WIDTH-1:0] src_rd_dout,
  input  logic                  src_rd_dout_vld,
  output logic [ADDR_WIDTH-1:0] dst_wr_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_din,
  output logic                  dst_wr_csb
);

  localparam int unsigned   CW      = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CREDITS = CW'(MAX_OUTSTANDING);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
  logic [ADDR_WIDTH-1:0] src_stride_q, src_stride_d;
  logic [ADDR_WIDTH-1:0] dst_stride_q, dst_stride_d;
  logic [LEN_WIDTH-1:0]  num_q, num_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  written_q, written_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic                  err_q, err_d;
  logic                  aborted_q, aborted_d;
  logic                  quiet_q, quiet_d;

  logic                  start_acc, rd, wr, pop, vld_ok;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;

`ifdef STRIDED_MOVER_FILL_EN
  logic                  fill_q;
  logic [DATA_WIDTH-1:0] fill_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (start_acc) begin
      fill_q     <= fill_mode;
      fill_val_q <= fill_value;
    end
  end
`else
  logic                  fill_q;
  logic [DATA_WIDTH-1:0] fill_val_q;
  logic                  unused_fill;

  assign fill_q      = 1'b0;
  assign fill_val_q  = '0;
  assign unused_fill = ^{fill_mode, fill_value};
`endif

  mover_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (vld_ok),
    .din_i   (src_rd_dout),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    src_addr_d    = src_addr_q;
    dst_addr_d    = dst_addr_q;
    src_stride_d  = src_stride_q;
    dst_stride_d  = dst_stride_q;
    num_d         = num_q;
    issued_d      = issued_q;
    written_d     = written_q;
    err_d         = err_q;
    aborted_d     = aborted_q;
    quiet_d       = quiet_q;
    start_acc     = 1'b0;
    rd            = 1'b0;
    wr            = 1'b0;
    pop           = 1'b0;
    wdata         = '0;

    // Responses with no read in flight are flagged, except stragglers after reset.
    vld_ok = src_rd_dout_vld && (outstanding_q != '0);
    if (src_rd_dout_vld && (outstanding_q == '0) && !quiet_q) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc    = 1'b1;
          src_addr_d   = src_base_addr;
          dst_addr_d   = dst_base_addr;
          src_stride_d = src_stride;
          dst_stride_d = dst_stride;
          num_d        = num_words;
          issued_d     = '0;
          written_d    = '0;
          err_d        = 1'b0;
          aborted_d    = 1'b0;
          quiet_d      = 1'b0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          if (fill_q) begin
            wr    = (written_q != num_q);
            wdata = fill_val_q;
          end else begin
            pop   = !fifo_empty;
            wr    = pop;
            wdata = fifo_head;
            // A head popped this cycle frees its credit for a same-cycle issue.
            rd    = (issued_q != num_q) &&
                    ((outstanding_q + fifo_count - CW'(pop)) < CREDITS);
          end
          if ((written_q + LEN_WIDTH'(wr)) == num_q) state_d = DONE;
        end
      end
      DRAIN: begin
        pop = !fifo_empty;
        if ((outstanding_q == '0) && (fifo_count == '0)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (rd) begin
      issued_d   = issued_q + LEN_WIDTH'(1);
      src_addr_d = src_addr_q + src_stride_q;
    end
    if (wr) begin
      written_d  = written_q + LEN_WIDTH'(1);
      dst_addr_d = dst_addr_q + dst_stride_q;
    end
    outstanding_d = outstanding_q + CW'(rd) - CW'(vld_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      src_addr_q    <= '0;
      dst_addr_q    <= '0;
      src_stride_q  <= '0;
      dst_stride_q  <= '0;
      num_q         <= '0;
      issued_q      <= '0;
      written_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      aborted_q     <= 1'b0;
      quiet_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      src_addr_q    <= src_addr_d;
      dst_addr_q    <= dst_addr_d;
      src_stride_q  <= src_stride_d;
      dst_stride_q  <= dst_stride_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      written_q     <= written_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      aborted_q     <= aborted_d;
      quiet_q       <= quiet_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign aborted     = done && aborted_q;
  assign err         = err_q;
  assign src_rd_addr = src_addr_q;
  assign src_rd_csb  = !rd;
  assign dst_wr_addr = dst_addr_q;
  assign dst_wr_din  = wdata;
  assign dst_wr_csb  = !wr;

endmodule
